// File: rtl/led_mode_sequencer.sv
// -----------------------------------------------------------------------------
// led_mode_sequencer
//
// Drives the three Pano front-panel LEDs from one of four display modes,
// selected by presses of PANO_BUTTON:
//   OFF     - all LEDs dark
//   COUNT   - 3-bit binary count, one step per display tick
//   CYCLE   - single lit LED rotating R -> B -> G, one step per display tick
//   BREATHE - all LEDs PWM-dimmed, duty ramping up and down once per period
//
// Internals: free-running tick prescaler, two-flop button synchronizer with
// a stable-count debouncer, the mode FSM and the PWM breathe engine.
//
// Optional build macro: LED_MODE_AUTO_ADVANCE_EN
//   When defined, the mode also advances by itself every AUTO_TICKS display
//   ticks (held off while the button is held down).
//
// Ports:
//   SYSCLK      in   system clock, every register is in this domain
//   RESET       in   asynchronous, active-high reset
//   PANO_BUTTON in   raw, asynchronous button input, 1 = pressed
//   LED_RED     out  registered LED drive, 1 = lit (led_reg[0])
//   LED_BLUE    out  registered LED drive, 1 = lit (led_reg[1])
//   LED_GREEN   out  registered LED drive, 1 = lit (led_reg[2])
//   MODE        out  current mode: 0 OFF, 1 COUNT, 2 CYCLE, 3 BREATHE
//   TICK        out  one-cycle pulse marking each display tick
// -----------------------------------------------------------------------------
module led_mode_sequencer #(
    parameter int TICK_DIV        = 25000000,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PWM_BITS        = 8,
    parameter int AUTO_TICKS      = 8
) (
    input  logic       SYSCLK,
    input  logic       RESET,
    input  logic       PANO_BUTTON,
    output logic       LED_RED,
    output logic       LED_BLUE,
    output logic       LED_GREEN,
    output logic [1:0] MODE,
    output logic       TICK
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Elaboration-time parameter sanity checks.
    if (TICK_DIV < 2)        $error("TICK_DIV must be at least 2");
    if (DEBOUNCE_CYCLES < 1) $error("DEBOUNCE_CYCLES must be at least 1");
    if (PWM_BITS < 1)        $error("PWM_BITS must be at least 1");
    if (AUTO_TICKS < 1)      $error("AUTO_TICKS must be at least 1");

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_COUNT   = 2'd1,
        MODE_CYCLE   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_OFF:   return MODE_COUNT;
            MODE_COUNT: return MODE_CYCLE;
            MODE_CYCLE: return MODE_BREATHE;
            default:    return MODE_OFF;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Display tick prescaler: free-running, never disturbed by mode changes.
    // -------------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic              tick_last;

    assign tick_last = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign TICK      = tick_last;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge value of its neighbours, independent of block ordering.
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            tick_cnt <= '0;
        end else if (tick_last) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Button: two-flop synchronizer, then a debouncer that flips its output
    // only after DEBOUNCE_CYCLES consecutive samples disagree with it.
    // -------------------------------------------------------------------------
    logic            sync_a;
    logic            sync_b;
    logic            deb;
    logic            deb_q;
    logic [DB_W-1:0] stable_cnt;
    logic            press;

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            deb        <= 1'b0;
            deb_q      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_a <= PANO_BUTTON;
            sync_b <= sync_a;
            deb_q  <= deb;
            if (sync_b == deb) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb        <= ~deb;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    // Rising edge of the debounced level only; release and hold are silent.
    assign press = deb & ~deb_q;

    // -------------------------------------------------------------------------
    // PWM counter: free-running in every mode.
    // -------------------------------------------------------------------------
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_wrap;

    assign pwm_wrap = &pwm_cnt;

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Mode advance request: button press, optionally OR'ed with auto-advance.
    // -------------------------------------------------------------------------
    logic advance;

`ifdef LED_MODE_AUTO_ADVANCE_EN
    localparam int AUTO_W = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;

    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_adv;

    // Ticks are ignored entirely while the button is held down.
    assign auto_adv = tick_last & ~deb & (auto_cnt == AUTO_W'(AUTO_TICKS - 1));

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            auto_cnt <= '0;
        end else if (press) begin
            auto_cnt <= '0;
        end else if (tick_last && !deb) begin
            auto_cnt <= auto_adv ? '0 : auto_cnt + 1'b1;
        end
    end

    // A coincident press and auto-advance still move the mode by one step.
    assign advance = press | auto_adv;
`else
    assign advance = press;
`endif

    // -------------------------------------------------------------------------
    // Mode FSM, LED pattern register and breathe duty engine.
    // -------------------------------------------------------------------------
    mode_t               mode;
    logic [2:0]          led_reg;
    logic [PWM_BITS-1:0] duty;
    logic                duty_up;
    logic [2:0]          led_next;
    logic [2:0]          led_q;

    // NOTE: default first, so every path through the case assigns led_next
    // and no latch is inferred.
    always_comb begin
        led_next = 3'b000;
        case (mode)
            MODE_COUNT,
            MODE_CYCLE:   led_next = led_reg;
            MODE_BREATHE: led_next = {3{pwm_cnt < duty}};
            default:      led_next = 3'b000;
        endcase
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            mode    <= MODE_COUNT;
            led_reg <= 3'b000;
            duty    <= '0;
            duty_up <= 1'b1;
            led_q   <= 3'b000;
        end else begin
            led_q <= led_next;
            if (advance) begin
                // Mode change has priority over any tick or PWM wrap in the
                // same cycle: only the entry values are loaded.
                mode    <= next_mode(mode);
                led_reg <= (next_mode(mode) == MODE_CYCLE) ? 3'b001 : 3'b000;
                duty    <= '0;
                duty_up <= 1'b1;
            end else begin
                case (mode)
                    MODE_COUNT: begin
                        if (tick_last) led_reg <= led_reg + 3'd1;
                    end
                    MODE_CYCLE: begin
                        if (tick_last) led_reg <= {led_reg[1:0], led_reg[2]};
                    end
                    MODE_BREATHE: begin
                        // Each endpoint is held for one extra period while
                        // the direction flips, giving 0..max, max..0.
                        if (pwm_wrap) begin
                            if (duty_up) begin
                                if (&duty) duty_up <= 1'b0;
                                else       duty    <= duty + 1'b1;
                            end else begin
                                if (duty == '0) duty_up <= 1'b1;
                                else            duty    <= duty - 1'b1;
                            end
                        end
                    end
                    default: led_reg <= 3'b000;
                endcase
            end
        end
    end

    assign LED_RED   = led_q[0];
    assign LED_BLUE  = led_q[1];
    assign LED_GREEN = led_q[2];
    assign MODE      = mode;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_mode_sequencer
//
// Self-checking bench for led_mode_sequencer with TICK_DIV=4,
// DEBOUNCE_CYCLES=3, PWM_BITS=3, AUTO_TICKS=2. A behavioural model derives
// the expected mode and LED pattern from counts of ticks and PWM periods
// since mode entry; a compare process checks TICK, MODE and the LEDs every
// cycle. Directed sequences pin the model with literal expectations, then
// randomized button activity (with occasional resets) runs against the model.
// Define LED_MODE_AUTO_ADVANCE_EN for both DUT and bench to test auto-advance.
// -----------------------------------------------------------------------------
module tb_led_mode_sequencer;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int PB = 3;
    localparam int AT = 2;
    localparam int PM = 1 << PB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       led_r;
    logic       led_b;
    logic       led_g;
    logic [1:0] mode_o;
    logic       tick_o;
    logic [2:0] led;

    int checks = 0;
    int errors = 0;

    assign led = {led_g, led_b, led_r};

    led_mode_sequencer #(
        .TICK_DIV       (TD),
        .DEBOUNCE_CYCLES(DB),
        .PWM_BITS       (PB),
        .AUTO_TICKS     (AT)
    ) dut (
        .SYSCLK     (clk),
        .RESET      (rst),
        .PANO_BUTTON(btn),
        .LED_RED    (led_r),
        .LED_BLUE   (led_b),
        .LED_GREEN  (led_g),
        .MODE       (mode_o),
        .TICK       (tick_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model. Expected display is a function of the mode and of how
    // many ticks / PWM periods have elapsed since that mode was entered.
    // -------------------------------------------------------------------------
    int         m_n     = 0;   // clock edges since reset release
    int         m_mode  = 1;
    int         m_ticks = 0;   // ticks applied since mode entry
    int         m_wraps = 0;   // PWM periods completed since BREATHE entry
    int         m_run   = 0;   // consecutive samples disagreeing with m_deb
    int         m_auto  = 0;
    bit         m_s1    = 0;
    bit         m_s2    = 0;
    bit         m_deb   = 0;
    bit         m_deb_q = 0;
    logic [2:0] m_led   = 3'b000;

    bit m_tick_now, m_wrap_now, m_press_now, m_auto_now;
    int m_pwm;

    // Triangle: 0,1,..,PM-1,PM-1,..,1,0 repeating every 2*PM periods.
    function automatic int tri_duty(input int w);
        int p;
        p = w % (2 * PM);
        return (p < PM) ? p : (2 * PM - 1 - p);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_mode = 1; m_ticks = 0; m_wraps = 0; m_run = 0; m_auto = 0;
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_q = 0; m_led = 3'b000;
        end else begin
            m_pwm       = m_n % PM;
            m_tick_now  = (m_n % TD) == (TD - 1);
            m_wrap_now  = (m_pwm == PM - 1);
            m_press_now = m_deb && !m_deb_q;
            case (m_mode)
                0:       m_led = 3'b000;
                1:       m_led = 3'(m_ticks % 8);
                2:       m_led = 3'(1 << (m_ticks % 3));
                default: m_led = (m_pwm < tri_duty(m_wraps)) ? 3'b111 : 3'b000;
            endcase
            m_auto_now = 0;
`ifdef LED_MODE_AUTO_ADVANCE_EN
            if (m_press_now) m_auto = 0;
            else if (m_tick_now && !m_deb) begin
                if (m_auto == AT - 1) begin m_auto_now = 1; m_auto = 0; end
                else m_auto++;
            end
`endif
            if (m_press_now || m_auto_now) begin
                m_mode = (m_mode + 1) % 4; m_ticks = 0; m_wraps = 0;
            end else begin
                if (m_tick_now) m_ticks++;
                if (m_wrap_now && m_mode == 3) m_wraps++;
            end
            m_deb_q = m_deb;
            if (m_s2 == m_deb) m_run = 0;
            else if (m_run + 1 == DB) begin m_deb = !m_deb; m_run = 0; end
            else m_run++;
            m_s2 = m_s1;
            m_s1 = btn;
            m_n++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_tick", 32'(tick_o), 32'((m_n % TD) == (TD - 1)));
            check("cyc_mode", 32'(mode_o), 32'(m_mode));
            check("cyc_led",  32'(led),    32'(m_led));
        end
    end

    // Global time limit so the run always terminates.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    int         n0;
    int         nchg;
    int         last;
    int         guard;
    int         oncnt [16];
    logic [2:0] seen  [4];
    logic [2:0] rot_exp [4]   = '{3'b001, 3'b010, 3'b100, 3'b001};
    int         duty_exp [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0};
`ifdef LED_MODE_AUTO_ADVANCE_EN
    int         auto_exp [5]  = '{2, 3, 0, 1, 2};
`else
    logic [2:0] cnt_exp [8]   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
`endif

    initial begin
        repeat (3) @(negedge clk);
        check("rst_led",  32'(led),    32'd0);
        check("rst_mode", 32'(mode_o), 32'd1);
        check("rst_tick", 32'(tick_o), 32'd0);

        // Reset release; tick phase plus COUNT sequence or auto-advance steps.
        rst = 1'b0;
        for (int n = 0; n <= 41; n++) begin
            if (n < 12) check("tick_phase", 32'(tick_o), 32'(n == 3 || n == 7 || n == 11));
`ifdef LED_MODE_AUTO_ADVANCE_EN
            if (n > 0 && n % 8 == 0) check("auto_mode", 32'(mode_o), 32'(auto_exp[n / 8 - 1]));
`else
            if (n >= 5 && n <= 33 && (n - 5) % 4 == 0)
                check("count_led", 32'(led), 32'(cnt_exp[(n - 5) / 4]));
`endif
            @(negedge clk);
        end

`ifdef LED_MODE_AUTO_ADVANCE_EN
        // Held button: one press 2 -> 3, then no auto-advance while held.
        for (int c = 0; c < 70; c++) begin
            btn = (c < 68);
            if (c >= 8 && c % 10 == 0) check("held_mode", 32'(mode_o), 32'd3);
            @(negedge clk);
        end
        btn = 1'b0;
        repeat (10) @(negedge clk);
`else
        // Bouncing input, then a clean hold: exactly one press, COUNT -> CYCLE.
        for (int i = 0; i < 4; i++) begin
            btn = (i % 2 == 0);
            @(negedge clk);
        end
        nchg = 0;
        last = -1;
        for (int c = 0; c < 30; c++) begin
            btn = (c < 10);
            if (c == 5) check("press_lat_pre",  32'(mode_o), 32'd1);
            if (c == 6) check("press_lat_post", 32'(mode_o), 32'd2);
            if (c >= 7 && nchg < 4 && int'(led) != last) begin
                seen[nchg] = led;
                last = int'(led);
                nchg++;
            end
            @(negedge clk);
        end
        check("single_press", 32'(mode_o), 32'd2);
        check("rot_changes",  32'(nchg),   32'd4);
        for (int i = 0; i < 4; i++) check("rot_seq", 32'(seen[i]), 32'(rot_exp[i]));

        // Align a press onto a tick cycle while led_reg = 100, entering
        // BREATHE exactly at a PWM wrap.
        guard = 0;
        while (!((m_n % 8 == 2) && m_mode == 2 && (m_ticks % 3 == 1) &&
                 !m_deb && m_run == 0 && !m_s1 && !m_s2) && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        check("align_timeout", 32'(guard < 200), 32'd1);
        for (int p = 0; p < 16; p++) oncnt[p] = 0;
        for (int c = 0; c < 135; c++) begin
            btn = (c < 10);
            if (c == 5) begin
                check("tick_press_mode_pre", 32'(mode_o), 32'd2);
                check("tick_press_led_pre",  32'(led),    32'd4);
            end
            if (c == 6) check("tick_press_mode", 32'(mode_o), 32'd3);
            if (c == 7) check("tick_press_no_rot", 32'(led), 32'd0);
            if (c >= 7) oncnt[(c - 7) / 8] += int'(led_r);
            @(negedge clk);
        end
        for (int p = 0; p < 16; p++) check("breathe_on_count", 32'(oncnt[p]), 32'(duty_exp[p]));

        // Asynchronous reset while lit: outputs clear before any clock edge.
        guard = 0;
        while (m_led == 3'b000 && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        check("lit_timeout", 32'(guard < 100), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_led",  32'(led),    32'd0);
        check("async_rst_mode", 32'(mode_o), 32'd1);
        check("async_rst_tick", 32'(tick_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            check("tick_after_rst", 32'(tick_o), 32'(n == 3));
            @(negedge clk);
        end
`endif

        // Randomized button activity with occasional asynchronous resets.
        for (int seg = 0; seg < 160; seg++) begin
            btn = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 14)) @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                #3;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        btn = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
- Drives the three Pano front-panel LEDs from a small set of display modes.
- The PANO_BUTTON input selects the mode.
- Internals: one prescaled tick generator, a button synchronizer and debouncer, a mode FSM and a PWM "breathe" engine.
- Sits directly under top. top instantiates it and ties its outputs to the LED pins.

Parameters:
- TICK_DIV, 25000000: SYSCLK cycles per display tick. Must be at least 2.
- DEBOUNCE_CYCLES, 250000: consecutive stable samples required before the debounced button changes. Must be at least 1.
- PWM_BITS, 8: width of the PWM counter and of the breathe duty register.
- AUTO_TICKS, 8: ticks per mode when the optional feature is compiled in.

Ports:
- SYSCLK  in  1: system clock; every register is in this domain.
- RESET  in  1: asynchronous, active-high reset.
- PANO_BUTTON  in  1: raw button input, asynchronous; 1 = pressed.
- LED_RED  out  1: registered LED drive, 1 = lit.
- LED_BLUE  out  1: registered LED drive, 1 = lit.
- LED_GREEN  out  1: registered LED drive, 1 = lit.
- MODE  out  2: current mode. 0 = OFF, 1 = COUNT, 2 = CYCLE, 3 = BREATHE.
- TICK  out  1: one-cycle pulse marking each display tick.

Behaviour:
- Reset (asynchronous, active-high) values:
  - LEDs = 0, TICK = 0, MODE = COUNT.
  - All counters = 0.
  - led_reg = 3'b000.
  - Debounced button = 0, synchronizer flops = 0.
  - duty = 0, breathe direction = up.
- Bit mapping: led_reg[0] drives RED, led_reg[1] drives BLUE, led_reg[2] drives GREEN. The outputs are registered, so an LED changes one cycle after led_reg or the PWM compare changes.
- Tick generator:
  - tick_cnt counts 0 to TICK_DIV-1, then wraps to 0.
  - TICK = 1 during the cycle in which tick_cnt == TICK_DIV-1. This gives exactly one pulse per TICK_DIV cycles.
  - The tick generator free-runs in every mode and is never reset by a mode change.
- Button path:
  - Two-flop synchronizer feeding the debouncer.
  - The stable counter clears whenever the synchronized sample equals the debounced value.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the debounced value toggles and the counter clears.
  - press = one-cycle pulse on a debounced 0->1 transition.
  - Release generates no event. A held button generates only one press.
- Mode FSM:
  - A press advances the mode: OFF -> COUNT -> CYCLE -> BREATHE -> OFF.
  - On mode entry, led_reg is loaded as follows:
    - OFF: 000.
    - COUNT: 000.
    - CYCLE: 001.
    - BREATHE: led_reg unused; duty = 0, direction = up.
- Per-mode behaviour:
  - OFF: all LEDs = 0.
  - COUNT: on each TICK, led_reg = led_reg + 1, modulo 8 (111 wraps to 000).
  - CYCLE: on each TICK, led_reg rotates left: 001 -> 010 -> 100 -> 001.
  - BREATHE:
    - pwm_cnt is a free-running PWM_BITS-bit counter.
    - All three LEDs = (pwm_cnt < duty).
    - On each pwm_cnt wrap (all ones -> 0), duty steps by 1 in the current direction.
    - Direction flips to down when duty reaches 2^PWM_BITS-1, and flips to up when duty reaches 0. Endpoint values are held for one PWM period each.
    - At duty = 0 the LEDs are always off.
- Simultaneous press and TICK in the same cycle: the mode change wins, the entry value is loaded, and that tick is not applied.
- RESET asserted mid-operation: all state returns to the reset values immediately. The first TICK after release comes TICK_DIV cycles later.

Optional Feature:
- Macro: LED_MODE_AUTO_ADVANCE_EN.
- Defined:
  - An auto counter counts TICK pulses. When it reaches AUTO_TICKS, the mode advances exactly as on a press, and the counter clears.
  - A press also clears the auto counter.
  - Auto-advance is suppressed while the debounced button is held.
  - If a press and an auto-advance coincide, the mode advances by one step only.
- Undefined: the mode changes only on a press. No auto counter logic is present.

Test Plan (bench parameters: TICK_DIV=4, DEBOUNCE_CYCLES=3, PWM_BITS=3, AUTO_TICKS=2):
1. Release reset, hold button at 0 -> TICK pulses at cycles 3, 7, 11, ... after reset release. In COUNT, {G,B,R} = 001, 010, ... and wraps from 111 to 000 on the 8th tick.
2. Button bounces 1,0,1,0, then held at 1 for 10 cycles -> exactly one press. MODE goes 1 -> 2, debounced 3 synchronizer cycles plus 2 synchronizer cycles after the input settles. LEDs load 001 and then rotate 010, 100, 001 on successive ticks.
3. Time the press so it lands on a TICK cycle while in CYCLE with led_reg = 100 -> MODE = 3, duty = 0, and no rotation occurs.
4. In BREATHE, observe 16 PWM periods -> duty ramps 0 to 7 to 0. Per-period LED on-counts are 0,1,...,7,7,6,...,0.
5. Assert RESET mid-BREATHE with LEDs lit -> LEDs = 0 and MODE = 1 in the same cycle, without waiting for a clock edge. The first TICK comes 4 cycles after reset release.
6. With LED_MODE_AUTO_ADVANCE_EN defined and no press -> MODE steps 1, 2, 3, 0, 1 every 2 ticks. With the button held, MODE stays fixed.
